// File: rtl/vga_vram_arbiter.sv
// Single-port frame-buffer arbiter: display fetch owns phase A of each active pixel slot,
// the writer gets every other slot. Optional macro VRAM_ARB_VBLANK_ONLY_EN confines writes to vblank.
module vga_vram_arbiter #(
  parameter int HD          = 640,
  parameter int VD          = 480,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int PIX_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_tick,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_din,
  input  logic [PIX_W-1:0]  ram_dout,
  output logic [PIX_W-1:0]  rgb
);

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } wr_state_e;

  localparam logic [ADDR_W:0] FB_WORDS = (ADDR_W + 1)'(FB_W * FB_H);

  wr_state_e         state_q, state_d;
  logic              err_q, err_d;
  logic              vid_lat_q;
  logic [PIX_W-1:0]  rgb_q;

  logic              video_on;
  logic              wr_slot;
  logic              in_range;
  logic              grant;
  logic [ADDR_W-1:0] fb_row, fb_col, disp_addr;

  assign video_on = (pix_x < 10'(HD)) && (pix_y < 10'(VD));
  assign in_range = {1'b0, wr_addr} < FB_WORDS;

`ifdef VRAM_ARB_VBLANK_ONLY_EN
  assign wr_slot = (pix_y >= 10'(VD));
`else
  assign wr_slot = pix_tick || !video_on;
`endif

  assign fb_row = ADDR_W'(pix_y >> SCALE_SHIFT);
  assign fb_col = ADDR_W'(pix_x >> SCALE_SHIFT);

  // Row*FB_W as a sum of shifted rows, one term per set bit of FB_W (160 -> <<7 + <<5).
  always_comb begin
    disp_addr = fb_col;
    for (int i = 0; i < ADDR_W; i++) begin
      if (FB_W[i]) disp_addr = disp_addr + (fb_row << i);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    grant   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_slot && wr_req) begin
          state_d = ST_ACK;
          err_d   = !in_range;
          grant   = in_range;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  assign ram_we   = grant;
  assign ram_addr = grant ? wr_addr : disp_addr;
  assign ram_din  = wr_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Phase A presents the fetch address; RAM data is valid in phase B and captured at its end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_lat_q <= 1'b0;
      rgb_q     <= '0;
    end else if (!pix_tick) begin
      vid_lat_q <= video_on;
    end else begin
      rgb_q     <= vid_lat_q ? ram_dout : '0;
    end
  end

  assign wr_ack = (state_q == ST_ACK);
  assign wr_err = wr_ack && err_q;
  assign rgb    = rgb_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: drives the sync counters and writer, models the RAM,
// and a negedge monitor checks every RAM write and every ack against queued expectations.
module tb_vga_vram_arbiter;

  localparam int ADDR_W = 15;
  localparam int PIX_W  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [9:0]        pix_x = '0;
  logic [9:0]        pix_y = '0;
  logic              pix_tick = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic              wr_ack, wr_err, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_din, rgb;
  logic [PIX_W-1:0]  ram_dout = '0;

  logic [PIX_W-1:0]  mem [0:(1<<ADDR_W)-1];
  logic              mem_ready = 1'b0;

  wr_t  exp_wr_q [$];
  logic exp_ack_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  vga_vram_arbiter dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .pix_tick(pix_tick),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout), .rgb(rgb)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write, cleared on the first clock.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
      mem_ready <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every RAM write and every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        check("write_expected", 32'(exp_wr_q.size() > 0), 1);
        if (exp_wr_q.size() > 0) begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("write_addr", 32'(ram_addr), 32'(e.addr));
          check("write_data", 32'(ram_din), 32'(e.data));
        end
        if (pix_x < 10'd640 && pix_y < 10'd480) check("write_in_phase_b", 32'(pix_tick), 1);
`ifdef VRAM_ARB_VBLANK_ONLY_EN
        check("write_in_vblank", 32'(pix_y >= 10'd480), 1);
`endif
      end
      if (wr_ack) begin
        check("ack_expected", 32'(exp_ack_q.size() > 0), 1);
        if (exp_ack_q.size() > 0) check("ack_err_flag", 32'(wr_err), 32'(exp_ack_q.pop_front()));
      end else if (wr_err) begin
        check("err_without_ack", 32'(wr_err), 0);
      end
    end
  end

  // Advance one clk of the 640x480 sync generator; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (pix_tick) begin
      pix_tick = 1'b0;
      if (pix_x == 10'd799) begin
        pix_x = '0;
        pix_y = (pix_y == 10'd524) ? 10'd0 : pix_y + 10'd1;
      end else begin
        pix_x = pix_x + 10'd1;
      end
    end else begin
      pix_tick = 1'b1;
    end
  endtask

  task automatic start(input int x, input int y);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    pix_tick = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d,
                          input logic exp_err, input int max_clk, output int n_clk);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (!exp_err) exp_wr_q.push_back(e);
    exp_ack_q.push_back(exp_err);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    n_clk   = 0;
    while (!wr_ack && n_clk < max_clk) begin
      step();
      n_clk++;
    end
    wr_req = 1'b0;
    if (!wr_ack) check("ack_timeout", 32'(wr_ack), 1);
  endtask

  initial begin
    // Reset state
    start(700, 10);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 32'(rgb), 0);
    check("reset_wr_ack", 32'(wr_ack), 0);
    check("reset_wr_err", 32'(wr_err), 0);
    check("reset_ram_we", 32'(ram_we), 0);
    reset = 1'b0;
    step();

    // Blanking write is granted in the first clk, ack follows one clk later
    start(700, 10);
    do_write(15'd5, 3'b101, 1'b0, 4, lat);
    check("hblank_ack_latency", 32'(lat), 1);
    step();

    // Out-of-range address is rejected; last valid address is written
    start(720, 10);
    do_write(15'd19200, 3'b111, 1'b1, 4, lat);
    check("oob_ack_latency", 32'(lat), 1);
    step();
    start(720, 11);
    do_write(15'd19199, 3'b011, 1'b0, 4, lat);
    check("last_addr_ack_latency", 32'(lat), 1);
    step();

    // Active video: display fetch wins phase A, write lands in phase B
    start(100, 50);
    wr_addr = 15'd1945;
    wr_data = 3'b110;
    wr_req  = 1'b1;
    @(negedge clk);
    check("phase_a_ram_addr", 32'(ram_addr), 1945);
    check("phase_a_ram_we", 32'(ram_we), 0);
    do_write(15'd1945, 3'b110, 1'b0, 6, lat);
    check("active_ack_latency", 32'(lat), 2);
    step();

    // Scan line 50: pixels 100..103 hold 3'b110, shown while pix_x = 101..104
    start(96, 50);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pix_x >= 10'd100 && pix_x <= 10'd105)
        check($sformatf("scan_rgb_x%0d_t%0d", pix_x, pix_tick), 32'(rgb),
              (pix_x >= 10'd101 && pix_x <= 10'd104) ? 32'd6 : 32'd0);
      if (pix_x == 10'd105 && pix_tick) break;
      step();
    end
    step();

    // Reset while the FSM is in ACK: ack and rgb clear at once, no late ack
    start(103, 50);
    step();
    step();
    check("pre_reset_rgb", 32'(rgb), 6);
    start(700, 20);
    begin
      wr_t e;
      e.addr = 15'd7;
      e.data = 3'b010;
      exp_wr_q.push_back(e);
    end
    wr_addr = 15'd7;
    wr_data = 3'b010;
    wr_req  = 1'b1;
    step();
    check("pre_reset_ack", 32'(wr_ack), 1);
    reset  = 1'b1;
    wr_req = 1'b0;
    #1;
    check("mid_ack_reset_rgb", 32'(rgb), 0);
    check("mid_ack_reset_wr_ack", 32'(wr_ack), 0);
    check("mid_ack_reset_wr_err", 32'(wr_err), 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_reset_no_ack", 32'(wr_ack), 0);
    end
    start(700, 21);
    do_write(15'd8, 3'b100, 1'b0, 4, lat);
    check("post_reset_ack_latency", 32'(lat), 1);
    step();

`ifdef VRAM_ARB_VBLANK_ONLY_EN
    // Requests in visible lines wait for vblank
    start(100, 100);
    wr_addr = 15'd9;
    wr_data = 3'b111;
    wr_req  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      check("vblank_only_no_ack", 32'(wr_ack), 0);
    end
    start(799, 479);
    step();
    step();
    do_write(15'd9, 3'b111, 1'b0, 4, lat);
    check("vblank_only_ack_within_2", 32'(lat <= 2), 1);
    step();
`endif

    repeat (2) step();
    check("writes_drained", 32'(exp_wr_q.size()), 0);
    check("acks_drained", 32'(exp_ack_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
